// File: rtl/tune_ramp_sequencer_if.sv
// Request channel for the tune ramp sequencer: a target FTW offered over valid/ready.
// The master offers targets; the slave (the sequencer) signals when it can take one.
interface tune_ramp_if;
    logic        req_valid;
    logic [31:0] req_ftw;
    logic        req_ready;

    modport master (
        output req_valid,
        output req_ftw,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ftw,
        output req_ready
    );
endinterface

// File: rtl/tune_ramp_sequencer.sv
// Tune ramp sequencer: slews the nominal FTW toward each accepted target in
// clamped, dwell-separated steps and gates the servo action onto the DDS tune
// adder only while idle.
// Optional build macro TUNE_ACTION_CLAMP_EN saturates the idle servo action to
// +/-ACTION_LIMIT before it is registered.
module tune_ramp_sequencer #(
    parameter logic        [31:0] INIT_FTW     = 32'd0,
    parameter logic        [31:0] STEP_MAX     = 32'd1024,
    parameter logic        [15:0] DWELL        = 16'd16,
    parameter logic signed [31:0] ACTION_LIMIT = 32'sd65536
) (
    input  logic                clk,
    input  logic                rst_n,
    tune_ramp_if.slave          req,
    input  logic                servo_en_i,
    input  logic signed [31:0]  servo_action_i,
    output logic        [31:0]  ftw_out_o,
    output logic signed [31:0]  action_out_o,
    output logic                adder_en_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_DWELL
    } state_t;

    localparam logic signed [31:0] STEP_POS = $signed(STEP_MAX);
    localparam logic signed [31:0] STEP_NEG = -STEP_POS;

    state_t             state_q, state_d;
    logic        [31:0] target_q, target_d;
    logic        [31:0] ftw_q, ftw_d;
    logic        [15:0] dwell_q, dwell_d;
    logic signed [31:0] action_q, action_d;
    logic               adder_en_q, adder_en_d;
    logic               done_q, done_d;

    logic signed [31:0] diff;
    logic signed [31:0] step;
    logic               step_final;
    logic               accept;
    logic               same_target;
    logic               target_hit;
    logic signed [31:0] servo_sel;

    // Shortest-path step toward the target, clamped to the per-step limit
    always_comb begin
        diff = $signed(target_q - ftw_q);
        step = diff;
        if (diff > STEP_POS) begin
            step = STEP_POS;
        end else if (diff < STEP_NEG) begin
            step = STEP_NEG;
        end
        step_final  = (step == diff);
        accept      = req.req_valid && (state_q == ST_IDLE);
        same_target = (req.req_ftw == ftw_q);
        target_hit  = (ftw_q == target_q);
    end

    // Servo action as it would be applied while idle (optionally saturated)
    always_comb begin
`ifdef TUNE_ACTION_CLAMP_EN
        if (servo_action_i > ACTION_LIMIT) begin
            servo_sel = ACTION_LIMIT;
        end else if (servo_action_i < -ACTION_LIMIT) begin
            servo_sel = -ACTION_LIMIT;
        end else begin
            servo_sel = servo_action_i;
        end
`else
        servo_sel = servo_action_i;
`endif
    end

    // State register; reset abandons any ramp in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, step, dwell, and return to idle on arrival
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !same_target) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (DWELL != 16'd0) begin
                    state_d = ST_DWELL;
                end else if (step_final) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_DWELL: begin
                if (dwell_q == 16'd0) begin
                    state_d = target_hit ? ST_IDLE : ST_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: servo gating, FTW stepping, dwell count, done pulse
    always_comb begin
        target_d   = target_q;
        ftw_d      = ftw_q;
        dwell_d    = dwell_q;
        action_d   = 32'sd0;
        adder_en_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    target_d = req.req_ftw;
                    done_d   = same_target;
                end else begin
                    adder_en_d = servo_en_i;
                    action_d   = servo_en_i ? servo_sel : 32'sd0;
                end
            end
            ST_STEP: begin
                ftw_d   = ftw_q + step;
                dwell_d = (DWELL != 16'd0) ? (DWELL - 16'd1) : 16'd0;
                done_d  = (DWELL == 16'd0) && step_final;
            end
            ST_DWELL: begin
                if (dwell_q != 16'd0) begin
                    dwell_d = dwell_q - 16'd1;
                end else begin
                    done_d = target_hit;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= INIT_FTW;
            ftw_q      <= INIT_FTW;
            dwell_q    <= 16'd0;
            action_q   <= 32'sd0;
            adder_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            target_q   <= target_d;
            ftw_q      <= ftw_d;
            dwell_q    <= dwell_d;
            action_q   <= action_d;
            adder_en_q <= adder_en_d;
            done_q     <= done_d;
        end
    end

    assign ftw_out_o     = ftw_q;
    assign action_out_o  = action_q;
    assign adder_en_o    = adder_en_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign req.req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_tune_ramp_sequencer.sv
// Self-checking bench for tune_ramp_sequencer: directed scenarios plus random
// requests/servo traffic, checked every cycle against a timeline model that
// expands each accepted request into its per-cycle FTW sequence.
module tb_tune_ramp_sequencer;

    localparam int STEP_LIM  = 1024;
    localparam int DWELL_CYC = 3;
    localparam logic signed [31:0] LIMIT = 32'sd65536;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               servoEn = 1'b0;
    logic signed [31:0] servoAction = 32'sd0;
    logic        [31:0] ftwOut;
    logic signed [31:0] actionOut;
    logic               adderEn;
    logic               busyOut;
    logic               doneOut;

    tune_ramp_if reqIf ();

    tune_ramp_sequencer #(
        .INIT_FTW    (32'd0),
        .STEP_MAX    (32'd1024),
        .DWELL       (16'd3),
        .ACTION_LIMIT(32'sd65536)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (reqIf),
        .servo_en_i    (servoEn),
        .servo_action_i(servoAction),
        .ftw_out_o     (ftwOut),
        .action_out_o  (actionOut),
        .adder_en_o    (adderEn),
        .busy_o        (busyOut),
        .done_o        (doneOut)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ftw;
        logic        last;
    } entry_t;

    entry_t      tl[$];
    logic [31:0] mFtw = 32'd0;
    logic [31:0] expFtw, expAct;
    logic        expEn, expDone, expBusy;
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] idleAction(input logic signed [31:0] a);
`ifdef TUNE_ACTION_CLAMP_EN
        if (a > LIMIT) return LIMIT;
        if (a < -LIMIT) return -LIMIT;
`endif
        return a;
    endfunction

    // Expand a ramp into one entry per clock edge: each step followed by the dwell cycles
    task automatic buildRamp(input logic [31:0] target);
        logic [31:0]        cur;
        logic signed [31:0] d;
        entry_t             e;
        cur = mFtw;
        while (cur != target) begin
            d = target - cur;
            if (d > STEP_LIM) d = STEP_LIM;
            else if (d < -STEP_LIM) d = -STEP_LIM;
            cur = cur + d;
            for (int j = 0; j <= DWELL_CYC; j++) begin
                e.ftw  = cur;
                e.last = (cur == target) && (j == DWELL_CYC);
                tl.push_back(e);
            end
        end
    endtask

    task automatic modelEdge();
        entry_t e;
        if (tl.size() > 0) begin
            e       = tl.pop_front();
            mFtw    = e.ftw;
            expFtw  = e.ftw;
            expBusy = !e.last;
            expDone = e.last;
            expEn   = 1'b0;
            expAct  = 32'd0;
        end else if (reqIf.req_valid) begin
            expFtw = mFtw;
            expEn  = 1'b0;
            expAct = 32'd0;
            if (reqIf.req_ftw == mFtw) begin
                expDone = 1'b1;
                expBusy = 1'b0;
            end else begin
                expDone = 1'b0;
                expBusy = 1'b1;
                buildRamp(reqIf.req_ftw);
            end
        end else begin
            expFtw  = mFtw;
            expDone = 1'b0;
            expBusy = 1'b0;
            expEn   = servoEn;
            expAct  = servoEn ? idleAction(servoAction) : 32'd0;
        end
    endtask

    task automatic checkAll();
        checkOutput("ftw_out", ftwOut, expFtw);
        checkOutput("action_out", actionOut, expAct);
        checkOutput("adder_en", adderEn, expEn);
        checkOutput("done", doneOut, expDone);
        checkOutput("busy", busyOut, expBusy);
        checkOutput("req_ready", reqIf.req_ready, !expBusy);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] t,
                                 input logic se, input logic signed [31:0] sa);
        reqIf.req_valid = v;
        reqIf.req_ftw   = t;
        servoEn         = se;
        servoAction     = sa;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_ftw", ftwOut, 32'd0);
        checkOutput("rst_action", actionOut, 32'd0);
        checkOutput("rst_adder_en", adderEn, 1'b0);
        checkOutput("rst_done", doneOut, 1'b0);
        checkOutput("rst_busy", busyOut, 1'b0);
        tl.delete();
        mFtw = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", reqIf.req_ready, 1'b1);
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'sd0);
    endtask

    initial begin
        logic               v;
        logic [31:0]        t;
        logic signed [31:0] sa;
        int                 doneAt;

        reqIf.req_valid = 1'b0;
        reqIf.req_ftw   = 32'd0;
        #1;
        resetDut();
        runIdle(2);

        $display("[TB] basic ramp 0 -> 3000");
        applyStimulus(1'b1, 32'd3000, 1'b0, 32'sd0);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 32'd7777, 1'b0, 32'sd0);
            case (i)
                1:  checkOutput("ramp_k1", ftwOut, 32'd1024);
                5:  checkOutput("ramp_k5", ftwOut, 32'd2048);
                9:  checkOutput("ramp_k9", ftwOut, 32'd3000);
                12: begin
                    checkOutput("ramp_done", doneOut, 1'b1);
                    checkOutput("ramp_ready", reqIf.req_ready, 1'b1);
                end
                default: ;
            endcase
        end
        runIdle(2);
        checkOutput("ramp_no_queue", ftwOut, 32'd3000);

        $display("[TB] servo gating");
        applyStimulus(1'b0, 32'd0, 1'b1, -32'sd500);
        checkOutput("servo_en", adderEn, 1'b1);
        checkOutput("servo_act", actionOut, -32'sd500);
        applyStimulus(1'b1, 32'd5000, 1'b1, 32'sd777);
        checkOutput("accept_gate", adderEn, 1'b0);
        for (int i = 0; i < 40 && tl.size() > 0; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'sd777);
            checkOutput("ramp_gate", adderEn, 1'b0);
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 32'sd777);
        checkOutput("servo_resume", adderEn, 1'b1);
        applyStimulus(1'b1, 32'd5000, 1'b0, 32'sd0);
        checkOutput("eq_done", doneOut, 1'b1);
        checkOutput("eq_ftw", ftwOut, 32'd5000);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'sd0);
        checkOutput("eq_done_clear", doneOut, 1'b0);

        $display("[TB] servo clamp");
        applyStimulus(1'b0, 32'd0, 1'b1, 32'sd100000);
`ifdef TUNE_ACTION_CLAMP_EN
        checkOutput("clamp_pos", actionOut, 32'sd65536);
`else
        checkOutput("pass_pos", actionOut, 32'sd100000);
`endif
        applyStimulus(1'b0, 32'd0, 1'b1, -32'sd100000);
`ifdef TUNE_ACTION_CLAMP_EN
        checkOutput("clamp_neg", actionOut, -32'sd65536);
`else
        checkOutput("pass_neg", actionOut, -32'sd100000);
`endif
        applyStimulus(1'b0, 32'd0, 1'b1, 32'sd1234);
        checkOutput("clamp_small", actionOut, 32'sd1234);

        $display("[TB] wrap-around");
        resetDut();
        applyStimulus(1'b1, 32'hFFFF_FC00, 1'b0, 32'sd0);
        runIdle(4);
        checkOutput("wrap_start", ftwOut, 32'hFFFF_FC00);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 32'sd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 32'sd0);
            if (i == 1) checkOutput("wrap_up1", ftwOut, 32'h0000_0000);
            if (i == 5) checkOutput("wrap_up2", ftwOut, 32'h0000_0200);
        end
        applyStimulus(1'b1, 32'hFFFF_FC00, 1'b0, 32'sd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 32'sd0);
            if (i == 1) checkOutput("wrap_dn1", ftwOut, 32'hFFFF_FE00);
            if (i == 5) checkOutput("wrap_dn2", ftwOut, 32'hFFFF_FC00);
        end

        $display("[TB] reset mid-ramp");
        resetDut();
        applyStimulus(1'b1, 32'd3000, 1'b0, 32'sd0);
        runIdle(6);
        resetDut();
        checkOutput("midrst_ftw", ftwOut, 32'd0);
        checkOutput("midrst_done", doneOut, 1'b0);
        applyStimulus(1'b1, 32'd3000, 1'b0, 32'sd0);
        doneAt = -1;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 32'sd0);
            if (doneOut && doneAt < 0) doneAt = i;
        end
        checkOutput("midrst_done_cycle", doneAt, 32'd12);
        checkOutput("midrst_final", ftwOut, 32'd3000);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) t = mFtw;
            else t = mFtw + $urandom_range(0, 12000) - 32'd6000;
            sa = $signed($urandom_range(0, 300000)) - 32'sd150000;
            applyStimulus(v, t, 1'($urandom_range(0, 1)), sa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
